// File: rtl/mac_pkg.sv
// Shared width helpers and the lane-slice macro for the MAC column
// (also used by the psum SRAM and OFIFO width checks).
`ifndef MAC_PKG_SV
`define MAC_PKG_SV
`define MAC_LANE(vec, k, w) vec[(w)*(k) +: (w)]
`endif

package mac_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // One lane product is 2*bw+2 bits, but the largest magnitude needs only 2*bw+1
    // bits, so summing pr of them adds clog2(pr) bits on top of that.
    function automatic int tree_width(input int bw, input int pr);
        return 2 * bw + 1 + clog2(pr);
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// One lane: extend both operands to bw+1 bits (sign or zero per beat) and multiply signed.
module mac_lane_mul #(
    parameter int bw = 8
) (
    input  logic [bw-1:0]          a_i,
    input  logic [bw-1:0]          b_i,
    input  logic                   signed_mode_i,
    output logic signed [2*bw+1:0] prod_o
);
    localparam int ProdW = 2 * bw + 2;

    logic signed [bw:0] aExt;
    logic signed [bw:0] bExt;

    assign aExt   = {signed_mode_i & a_i[bw-1], a_i};
    assign bExt   = {signed_mode_i & b_i[bw-1], b_i};
    assign prod_o = ProdW'(aExt) * ProdW'(bExt);

endmodule

// File: rtl/mac_pr_acc.sv
// Pipelined pr-lane MAC: registered products, registered adder tree, frame accumulator
// with optional saturation and a sticky overflow flag, then a registered result port.
module mac_pr_acc
    import mac_pkg::*;
#(
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int bw_psum = 24,
    parameter bit sat     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [pr*bw-1:0]   a,
    input  logic [pr*bw-1:0]   b,
    input  logic               signed_mode,
    input  logic               first,
    input  logic               last,
    output logic [bw_psum-1:0] out,
    output logic               out_valid,
    output logic               out_ovf
);
    localparam int ProdW = 2 * bw + 2;
    localparam int TreeW = tree_width(bw, pr);
    localparam int AccW  = bw_psum + 1;

    localparam logic signed [bw_psum-1:0] AccMax = {1'b0, {(bw_psum-1){1'b1}}};
    localparam logic signed [bw_psum-1:0] AccMin = {1'b1, {(bw_psum-1){1'b0}}};

    logic signed [ProdW-1:0]   prodComb [pr];
    logic signed [ProdW-1:0]   prod_q   [pr];
    logic                      v1_q, first1_q, last1_q;
    logic signed [TreeW-1:0]   treeSum;
    logic signed [TreeW-1:0]   sum_q;
    logic                      v2_q, first2_q, last2_q;
    logic signed [AccW-1:0]    sumWide;
    logic                      ovfNow;
    logic signed [bw_psum-1:0] acc_q, acc_d;
    logic                      ovf_q, ovf_d;
    logic                      emit_q;
    logic [bw_psum-1:0]        out_q;
    logic                      out_ovf_q, out_valid_q;

    for (genvar k = 0; k < pr; k++) begin : gLane
        mac_lane_mul #(.bw(bw)) uMul (
            .a_i          (`MAC_LANE(a, k, bw)),
            .b_i          (`MAC_LANE(b, k, bw)),
            .signed_mode_i(signed_mode),
            .prod_o       (prodComb[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            for (int k = 0; k < pr; k++) prod_q[k] <= '0;
        end else begin
            v1_q     <= in_valid;
            first1_q <= first;
            last1_q  <= last;
            prod_q   <= prodComb;
        end
    end

    always_comb begin
        treeSum = '0;
        for (int k = 0; k < pr; k++) treeSum = treeSum + TreeW'(prod_q[k]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q    <= '0;
            v2_q     <= 1'b0;
            first2_q <= 1'b0;
            last2_q  <= 1'b0;
        end else begin
            sum_q    <= treeSum;
            v2_q     <= v1_q;
            first2_q <= first1_q;
            last2_q  <= last1_q;
        end
    end

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sumWide = AccW'(acc_q) + AccW'(sum_q);
    assign ovfNow  = sumWide[AccW-1] ^ sumWide[AccW-2];

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (v2_q) begin
            if (first2_q) begin
                acc_d = bw_psum'(sum_q);
                ovf_d = 1'b0;
            end else if (ovfNow) begin
                ovf_d = 1'b1;
                if (sat) acc_d = sumWide[AccW-1] ? AccMin : AccMax;
                else     acc_d = sumWide[bw_psum-1:0];
            end else begin
                acc_d = sumWide[bw_psum-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            emit_q      <= 1'b0;
            out_q       <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            emit_q      <= v2_q & last2_q;
            out_valid_q <= emit_q;
            if (emit_q) begin
                out_q     <= acc_q;
                out_ovf_q <= ovf_q;
            end
        end
    end

    assign out       = out_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_pr_acc.sv
// Scoreboard bench for mac_pr_acc: three configurations share one stimulus stream,
// an arithmetic reference model queues expected results, a monitor pops and compares.
module tb_mac_pr_acc;
    localparam int BW = 8;
    localparam int PR = 16;
    localparam int ND = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, signed_mode, first, last;
    logic [PR*BW-1:0]  a, b;
    logic [23:0]       out0;
    logic [20:0]       out1, out2;
    logic              ov0, ov1, ov2;
    logic              of0, of1, of2;

    always #5 clk = ~clk;

    mac_pr_acc #(.bw(BW), .pr(PR), .bw_psum(24), .sat(1'b1)) uDut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .signed_mode(signed_mode), .first(first), .last(last),
        .out(out0), .out_valid(ov0), .out_ovf(of0));
    mac_pr_acc #(.bw(BW), .pr(PR), .bw_psum(21), .sat(1'b1)) uDut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .signed_mode(signed_mode), .first(first), .last(last),
        .out(out1), .out_valid(ov1), .out_ovf(of1));
    mac_pr_acc #(.bw(BW), .pr(PR), .bw_psum(21), .sat(1'b0)) uDut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .signed_mode(signed_mode), .first(first), .last(last),
        .out(out2), .out_valid(ov2), .out_ovf(of2));

    typedef struct {
        longint val0, val1, val2;
        bit     ovf0, ovf1, ovf2;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    longint modelAcc [ND];
    bit     modelOvf [ND];
    int     widths   [ND] = '{24, 21, 21};
    bit     sats     [ND] = '{1'b1, 1'b1, 1'b0};
    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic longint laneVal(input logic [7:0] x, input bit sm);
        return sm ? longint'($signed(x)) : longint'(x);
    endfunction

    // Reference: plain dot product, then frame accumulation with range check on integers.
    task automatic modelBeat(input bit sm, input bit f, input bit l,
                             input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv);
        longint dot, s, lim, span;
        exp_t   e;
        dot = 0;
        for (int k = 0; k < PR; k++)
            dot += laneVal(av[k*BW +: BW], sm) * laneVal(bv[k*BW +: BW], sm);
        for (int d = 0; d < ND; d++) begin
            lim  = 64'sd1 <<< (widths[d] - 1);
            span = 64'sd1 <<< widths[d];
            if (f) begin
                modelAcc[d] = dot;
                modelOvf[d] = 1'b0;
            end else begin
                s = modelAcc[d] + dot;
                if (s >= lim || s < -lim) begin
                    modelOvf[d] = 1'b1;
                    if (sats[d]) s = (s < 0) ? -lim : lim - 1;
                    else begin
                        s = s & (span - 1);
                        if (s >= lim) s -= span;
                    end
                end
                modelAcc[d] = s;
            end
        end
        if (l) begin
            e.val0 = modelAcc[0]; e.val1 = modelAcc[1]; e.val2 = modelAcc[2];
            e.ovf0 = modelOvf[0]; e.ovf1 = modelOvf[1]; e.ovf2 = modelOvf[2];
            e.cyc  = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit sm, input bit f, input bit l,
                                 input logic [PR*BW-1:0] av, input logic [PR*BW-1:0] bv);
        @(negedge clk);
        in_valid    = v;
        signed_mode = sm;
        first       = f;
        last        = l;
        a           = av;
        b           = bv;
        if (v) modelBeat(sm, f, l, av, bv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic resetDut(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
        for (int d = 0; d < ND; d++) begin
            modelAcc[d] = 0;
            modelOvf[d] = 1'b0;
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [PR*BW-1:0] fill(input logic [7:0] x);
        return {PR{x}};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checkOutput("out_valid missing", 0, 1);
        end
        if (ov0 === 1'b1 || ov1 === 1'b1 || ov2 === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("latency", cyc, e.cyc);
                checkOutput("out_valid0", longint'(ov0), 1);
                checkOutput("out_valid1", longint'(ov1), 1);
                checkOutput("out_valid2", longint'(ov2), 1);
                checkOutput("out0", longint'($signed(out0)), e.val0);
                checkOutput("out1", longint'($signed(out1)), e.val1);
                checkOutput("out2", longint'($signed(out2)), e.val2);
                checkOutput("out_ovf0", longint'(of0), longint'(e.ovf0));
                checkOutput("out_ovf1", longint'(of1), longint'(e.ovf1));
                checkOutput("out_ovf2", longint'(of2), longint'(e.ovf2));
            end
        end
    end

    initial begin
        logic [PR*BW-1:0] ra, rb;
        bit rv, rf, rl, rs;
        reset = 1'b1; in_valid = 1'b0; signed_mode = 1'b0;
        first = 1'b0; last = 1'b0; a = '0; b = '0;
        resetDut(3);
        @(negedge clk);
        checkOutput("reset out0", longint'(out0), 0);
        checkOutput("reset out1", longint'(out1), 0);
        checkOutput("reset out_valid", longint'({ov0, ov1, ov2}), 0);
        checkOutput("reset out_ovf", longint'({of0, of1, of2}), 0);

        applyStimulus(1, 1, 1, 1, fill(8'h80), fill(8'h80));
        idle(5);
        applyStimulus(1, 0, 1, 1, fill(8'hFF), fill(8'hFF));
        applyStimulus(1, 1, 1, 1, fill(8'hFF), fill(8'hFF));
        idle(5);

        applyStimulus(1, 1, 1, 0, fill(8'd3), fill(8'hFE));
        applyStimulus(1, 1, 0, 0, fill(8'd3), fill(8'hFE));
        idle(1);
        applyStimulus(1, 1, 0, 0, fill(8'd3), fill(8'hFE));
        applyStimulus(1, 1, 0, 1, fill(8'd3), fill(8'hFE));
        idle(5);

        applyStimulus(1, 1, 1, 0, fill(8'd1), fill(8'd1));
        applyStimulus(1, 1, 0, 1, fill(8'd1), fill(8'd1));
        applyStimulus(1, 1, 1, 1, fill(8'd2), fill(8'd5));
        idle(5);

        for (int i = 0; i < 5; i++)
            applyStimulus(1, 1, i == 0, i == 4, fill(8'h80), fill(8'h80));
        applyStimulus(1, 1, 1, 1, fill(8'd1), fill(8'd1));
        idle(5);

        applyStimulus(1, 1, 1, 1, fill(8'd7), fill(8'd9));
        resetDut(2);
        idle(6);
        checkOutput("post-reset out0", longint'(out0), 0);
        checkOutput("post-reset out2", longint'(out2), 0);
        applyStimulus(1, 1, 0, 1, fill(8'hFD), fill(8'd4));
        idle(5);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < PR; k++) begin
                ra[k*BW +: BW] = 8'($urandom);
                rb[k*BW +: BW] = 8'($urandom);
            end
            rv = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 4) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rs = 1'($urandom);
            applyStimulus(rv, rs, rf, rl, ra, rb);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(2);
        while (sb.size() > 0) begin
            void'(sb.pop_front());
            checkOutput("out_valid never arrived", 0, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_pr_acc.md
Name: mac_pr_acc

Overview:
- Parametrised, pipelined successor to the 16-input combinational MAC: pr-lane dot product with a registered adder tree and a frame accumulator.
- Per-beat selection of signed or unsigned operands, a valid/first/last framing handshake, optional saturation and a sticky overflow flag.
- Sits between the activation/weight feeders and the psum SRAM/OFIFO in the PE column.
- Accumulates one output-channel psum over any number of input beats.

Parameters:
- bw, 8, operand width per lane.
- pr, 16, parallel factor (number of lanes); power of 2, at least 2.
- bw_psum, 24, accumulator/output width; must be ≥ bw_tree = 2*bw+1+clog2(pr) (21 at defaults).
- sat, 1, 1 = saturate accumulator on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier for a, b, signed_mode, first, last.
- a  in  pr*bw  lane operands; lane k = a[bw*(k+1)-1:bw*k].
- b  in  pr*bw  lane operands, same packing as a.
- signed_mode  in  1  1 = a, b two's complement; 0 = unsigned; sampled per beat.
- first  in  1  beat starts a new accumulation (discards prior sum).
- last  in  1  beat ends the accumulation; result emitted.
- out  out  bw_psum  accumulated psum, signed two's complement.
- out_valid  out  1  one-cycle pulse; out holds the result until the next pulse.
- out_ovf  out  1  overflow seen in the frame just emitted; valid with out_valid.

Behaviour:
- Reset values: all stage valids, accumulator, out, out_valid and out_ovf are 0. Reset mid-frame discards all in-flight beats; no out_valid follows.
- Operand extension: each lane operand is extended to bw+1 bits, with the top bit = signed_mode ? msb : 0. The signed product is 2*bw+2 bits.
- S1 (cycle after accept): products registered; in_valid, first, last propagate alongside.
- S2: signed sum of the pr products at width bw_tree, registered. The tree may be split internally but must keep S2 timing: total latency is fixed.
- S3 (accumulate):
  - first=1: acc <= sign-extended tree sum; ovf <= 0.
  - otherwise: acc <= acc + tree sum, computed at bw_psum+1 bits. On overflow, ovf <= 1 and acc <= clamp to +2^(bw_psum-1)-1 / -2^(bw_psum-1) if sat=1, else wrapped value.
- Output on a last beat at S3: out <= new acc value; out_ovf <= new ovf value; out_valid pulses the next cycle.
- Latency: out_valid is asserted exactly 3 cycles after the clock edge that accepts the last beat.
- Bubbles (in_valid=0): no state change in S3; valids shift normally.
- first and last on the same beat: single-beat dot product.
- Back-to-back frames: first on the beat right after last is legal; full throughput, 1 beat/cycle, no stall.
- Beat with first=0 before any first since reset: accumulates onto 0.
- first reasserted mid-frame: the prior partial sum is dropped silently.
- Inputs are ignored when in_valid=0 (first and last are don't-care).
- No backpressure: the consumer must accept every out_valid.

Decomposition:
- Shared package/header (mac_pkg): bw_tree derivation function, clog2 function, lane-slice macro. Reuse in the psum SRAM and OFIFO width checks.
- One sub-module: mac_lane_mul (one extended (bw+1)x(bw+1) signed multiplier), generate-instantiated pr times.
- Adder tree, accumulator and control stay in mac_pr_acc.

Test Plan:
- Signed single beat, all lanes a=-128, b=-128, first=last=1 -> out=262144, out_valid exactly 3 cycles after the accept edge, out_ovf=0.
- Unsigned single beat, all lanes a=255, b=255, signed_mode=0 -> out=1040400; the same operands with signed_mode=1 -> out=16.
- Frame of 4 beats (lanes a=3, b=-2), first on beat 0, last on beat 3, one bubble between beats 1 and 2 -> out=-384, exactly one out_valid pulse.
- Back-to-back frames (F1: lanes a=1, b=1, 2 beats; F2: lanes a=2, b=5, 1 beat) with no gap -> out=32 then out=160 on consecutive cycles.
- Overflow with sat=1, bw_psum=21, signed, 5 beats of lanes a=-128, b=-128 -> out=1048575, out_ovf=1. With sat=0 -> out=-786432, out_ovf=1. The next frame starting with first -> out_ovf=0.
- reset asserted one cycle after a last beat is accepted -> no out_valid; out=0. A frame started the cycle after reset deasserts computes correctly.
